prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream boot stage for the 8-bit accumulator CPU.
- Accepts a program byte stream over a valid/ready handshake and writes it into the CPU's 32x8 instruction/data memory, holding the CPU in reset while it does so.
- Once loading completes, releases the CPU from reset and counts run cycles until the CPU asserts halt.
- Sits between the external host interface and the CPU core's memory write port and reset input.

Parameters:
- DWIDTH, 8, data/byte width; matches the memory word.
- AWIDTH, 5, memory address width; depth = 2**AWIDTH.
- CWIDTH, 16, width of the run-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  host byte valid.
- in_data  input  DWIDTH  host byte.
- in_last  input  1  marks the final byte of the program.
- in_ready  output  1  loader can accept a byte this cycle.
- start_load  input  1  single-cycle request to reload; honoured only in HALTED.
- mem_wr  output  1  memory write strobe, registered.
- mem_addr  output  AWIDTH  memory write address, registered.
- mem_data  output  DWIDTH  memory write data, registered.
- cpu_rst  output  1  reset to the CPU core, registered, active-high.
- cpu_halt  input  1  halt from the CPU controller.
- load_done  output  1  high in RUN and HALTED.
- byte_count  output  AWIDTH+1  bytes written in the last load.
- run_cycles  output  CWIDTH  cycles spent in RUN; saturates at all-ones.

Behaviour:
- States: LOAD, FLUSH, RUN, HALTED (plus ERROR with the optional feature).
- Reset (async): state=LOAD, in_ready=0, mem_wr=0, mem_addr=0, mem_data=0, cpu_rst=1, load_done=0, byte_count=0, run_cycles=0, internal write pointer wptr=0.
- in_ready is registered. It is 1 in LOAD, except in the first cycle after reset deasserts, where it is 0. It is 0 in every other state.
- Accept occurs when in_valid & in_ready.
- Write latency: a byte accepted in cycle N appears as mem_wr=1, mem_addr=wptr, mem_data=in_data in cycle N+1. mem_wr is a one-cycle pulse per accepted byte. wptr and byte_count increment on each accept.
- Back-to-back accepts are allowed, giving one write per cycle.
- Host may drop in_valid at any time; no write occurs in that cycle.
- Accept with in_last=1: in_ready drops in the next cycle; state goes to FLUSH.
- Accept at wptr = 2**AWIDTH-1 without in_last: same as in_last, i.e. auto-terminate. wptr never wraps; byte_count=32.
- FLUSH: one cycle, so the final write completes while cpu_rst=1. Then go to RUN.
- RUN: cpu_rst=0 starting the cycle after FLUSH; load_done=1; run_cycles increments every cycle and saturates.
  - cpu_halt=1 in RUN moves to HALTED next cycle.
  - cpu_halt is ignored in LOAD and FLUSH (the CPU is in reset).
- HALTED: cpu_rst stays 0 and run_cycles freezes.
  - start_load=1 moves to LOAD: cpu_rst=1 the next cycle, wptr=0, byte_count=0, run_cycles=0, load_done=0.
  - start_load is ignored in all other states.
- start_load and cpu_halt in the same cycle in RUN: the halt is taken and start_load is dropped.
- in_valid outside LOAD is ignored and produces no write.
- Asserting rst mid-load aborts the load. Memory contents are not cleared; after reset the load restarts at address 0.

Optional Feature:
- Macro: PROG_LOADER_CKSUM_EN.
- Defined:
  - The byte accepted with in_last is a checksum and is not written to memory.
  - The loader keeps an 8-bit modulo-2**DWIDTH sum of the written bytes; the sum resets with wptr.
  - If the checksum byte equals the sum: go to FLUSH, then RUN.
  - Otherwise: go to ERROR. In ERROR: cpu_rst=1, load_done=0, and output cksum_err=1 (reset value 0).
  - ERROR is exited only by start_load, which goes to LOAD and clears cksum_err.
  - Auto-terminate at a full memory skips the check and goes directly to FLUSH.
- Undefined: no cksum_err port, no ERROR state; the in_last byte is ordinary data.

Decomposition:
- Package prog_loader_pkg holds:
  - the state enum (LOAD, FLUSH, RUN, HALTED, ERROR);
  - default widths DWIDTH=8, AWIDTH=5, CWIDTH=16;
  - MEM_DEPTH=2**AWIDTH.
- One natural sub-module: sat_counter, a parameterised saturating counter with clear and enable, used for run_cycles.

Test Plan:
- Reset, then stream bytes 0x11,0x22,0x33 (last on 0x33) with in_valid held high -> mem_wr at 3 consecutive cycles, addr 0,1,2 with matching data; byte_count=3; cpu_rst falls 2 cycles after the last accept.
- Stream 32 bytes with no in_last -> 32 writes to addr 0..31; in_ready=0 after the 32nd accept; state RUN; no 33rd write even if in_valid stays high.
- In_valid gaps (pattern 1,0,0,1) during load -> writes only on accept cycles, addresses contiguous.
- After load, run 10 cycles then pulse cpu_halt -> run_cycles=10 and frozen; start_load pulse -> cpu_rst=1, run_cycles=0, in_ready=1 the next cycle.
- Assert rst after 2 of 4 bytes -> all outputs at reset values; the next load starts writing at addr 0.
- With PROG_LOADER_CKSUM_EN, send 0x01,0x02 then checksum 0x04 -> 2 writes, ERROR, cksum_err=1, cpu_rst stays 1. Repeat with checksum 0x03 -> RUN, cksum_err=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared widths and FSM state encoding for the program loader
//   DWIDTH/AWIDTH/CWIDTH : default byte, address and run-counter widths
//   MEM_DEPTH            : instruction/data memory depth
//   state_t              : loader FSM states (ERROR only reachable with PROG_LOADER_CKSUM_EN)
package prog_loader_pkg;
    localparam int DWIDTH    = 8;
    localparam int AWIDTH    = 5;
    localparam int CWIDTH    = 16;
    localparam int MEM_DEPTH = 2 ** AWIDTH;
    typedef enum logic [2:0] {LOAD, FLUSH, RUN, HALTED, ERROR} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and enable
//   clk, rst : clock, async active-high reset
//   clr      : clear to zero (wins over en)
//   en       : count up by one, holding at all-ones
//   cnt      : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (en && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot loader streaming a program into CPU memory, then running the CPU until halt
//   clk, rst                          : clock, async active-high reset
//   in_valid/in_data/in_last/in_ready : host byte stream (valid/ready)
//   start_load                        : reload request, honoured in HALTED (and ERROR)
//   mem_wr/mem_addr/mem_data          : registered memory write port
//   cpu_rst, cpu_halt                 : CPU reset out, CPU halt in
//   load_done, byte_count, run_cycles : status
//   cksum_err                         : checksum mismatch, only with PROG_LOADER_CKSUM_EN
//                                       (in_last byte becomes a checksum, not data)
module prog_loader #(
    parameter int DWIDTH = prog_loader_pkg::DWIDTH,
    parameter int AWIDTH = prog_loader_pkg::AWIDTH,
    parameter int CWIDTH = prog_loader_pkg::CWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              start_load,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              cpu_rst,
    input  logic              cpu_halt,
`ifdef PROG_LOADER_CKSUM_EN
    output logic              cksum_err,
`endif
    output logic              load_done,
    output logic [AWIDTH:0]   byte_count,
    output logic [CWIDTH-1:0] run_cycles
);
    import prog_loader_pkg::*;
    localparam int DEPTH = 2 ** AWIDTH;
    state_t state_q, state_d;
    logic in_ready_q, in_ready_d, mem_wr_q, mem_wr_d, cpu_rst_q, cpu_rst_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_data_q, mem_data_d;
    // byte_count doubles as the write pointer; it only reaches DEPTH when loading ends
    logic [AWIDTH:0] byte_count_q, byte_count_d;
    logic accept, full, reload, wr;
    assign accept = in_valid & in_ready_q;
    assign full   = byte_count_q == (AWIDTH+1)'(DEPTH - 1);
    assign reload = start_load & (state_q == HALTED || state_q == ERROR);
`ifdef PROG_LOADER_CKSUM_EN
    logic [DWIDTH-1:0] sum_q, sum_d;
    logic cks_byte;
    // a full memory auto-terminates, so the byte landing in the last slot is data
    assign cks_byte = accept & in_last & ~full;
    assign wr       = accept & ~cks_byte;
    assign cksum_err = state_q == ERROR;
    always_comb sum_d = reload ? '0 : wr ? sum_q + in_data : sum_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
`else
    assign wr = accept;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (accept && (in_last || full)) state_d = FLUSH;
`ifdef PROG_LOADER_CKSUM_EN
                if (cks_byte && in_data != sum_q) state_d = ERROR;
`endif
            end
            FLUSH:   state_d = RUN;
            RUN:     if (cpu_halt) state_d = HALTED;
            default: if (start_load) state_d = LOAD;
        endcase
    end
    always_comb begin
        in_ready_d   = state_d == LOAD;
        cpu_rst_d    = !(state_d == RUN || state_d == HALTED);
        mem_wr_d     = wr;
        mem_addr_d   = wr ? byte_count_q[AWIDTH-1:0] : mem_addr_q;
        mem_data_d   = wr ? in_data : mem_data_q;
        byte_count_d = reload ? '0 : byte_count_q + (AWIDTH+1)'(wr);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            in_ready_q   <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            cpu_rst_q    <= 1'b1;
            byte_count_q <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            cpu_rst_q    <= cpu_rst_d;
            byte_count_q <= byte_count_d;
        end
    sat_counter #(.W(CWIDTH)) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .clr (reload),
        .en  (state_q == RUN),
        .cnt (run_cycles)
    );
    assign in_ready   = in_ready_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign cpu_rst    = cpu_rst_q;
    assign byte_count = byte_count_q;
    assign load_done  = state_q == RUN || state_q == HALTED;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader
module tb_prog_loader;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, start_load = 1'b0, cpu_halt = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, mem_wr, cpu_rst, load_done;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic [5:0] byte_count;
    logic [15:0] run_cycles;
`ifdef PROG_LOADER_CKSUM_EN
    logic cksum_err;
`endif
    int errors = 0, checks = 0;

    prog_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .start_load(start_load), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data(mem_data), .cpu_rst(cpu_rst), .cpu_halt(cpu_halt),
`ifdef PROG_LOADER_CKSUM_EN
        .cksum_err(cksum_err),
`endif
        .load_done(load_done), .byte_count(byte_count), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_wr got %b want 0", mem_wr); end
        checks++; if (mem_addr !== 5'd0 || mem_data !== 8'h00) begin errors++; $display("FAIL rst_mem got %h/%h want 0/0", mem_addr, mem_data); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst got %b want 1", cpu_rst); end
        checks++; if (load_done !== 1'b0 || byte_count !== 6'd0 || run_cycles !== 16'd0) begin errors++; $display("FAIL rst_status got %b/%0d/%0d want 0/0/0", load_done, byte_count, run_cycles); end
        rst = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL first_cycle_in_ready got %b want 0", in_ready); end
        tick;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_stream3;
        in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 5'd0 || mem_data !== 8'h11) begin errors++; $display("FAIL s3_w0 got %b/%h/%h want 1/00/11", mem_wr, mem_addr, mem_data); end
        in_data = 8'h22;
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 5'd1 || mem_data !== 8'h22) begin errors++; $display("FAIL s3_w1 got %b/%h/%h want 1/01/22", mem_wr, mem_addr, mem_data); end
        in_data = 8'h33; in_last = 1'b1;
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 5'd2 || mem_data !== 8'h33) begin errors++; $display("FAIL s3_w2 got %b/%h/%h want 1/02/33", mem_wr, mem_addr, mem_data); end
        checks++; if (in_ready !== 1'b0 || cpu_rst !== 1'b1 || byte_count !== 6'd3) begin errors++; $display("FAIL s3_flush got rdy=%b rst=%b cnt=%0d want 0/1/3", in_ready, cpu_rst, byte_count); end
        tick;
        checks++; if (mem_wr !== 1'b0 || cpu_rst !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL s3_run got wr=%b rst=%b done=%b want 0/0/1", mem_wr, cpu_rst, load_done); end
    endtask

    task automatic test_run_halt;
        checks++; if (run_cycles !== 16'd0) begin errors++; $display("FAIL rh_start got %0d want 0", run_cycles); end
        repeat (9) tick;
        checks++; if (run_cycles !== 16'd9) begin errors++; $display("FAIL rh_count got %0d want 9", run_cycles); end
        cpu_halt = 1'b1;
        tick;
        cpu_halt = 1'b0;
        checks++; if (run_cycles !== 16'd10 || load_done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL rh_halt got cyc=%0d done=%b rst=%b want 10/1/0", run_cycles, load_done, cpu_rst); end
        repeat (3) tick;
        checks++; if (run_cycles !== 16'd10) begin errors++; $display("FAIL rh_frozen got %0d want 10", run_cycles); end
        start_load = 1'b1;
        tick;
        start_load = 1'b0;
        checks++; if (cpu_rst !== 1'b1 || run_cycles !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rh_reload got rst=%b cyc=%0d rdy=%b want 1/0/1", cpu_rst, run_cycles, in_ready); end
        checks++; if (load_done !== 1'b0 || byte_count !== 6'd0) begin errors++; $display("FAIL rh_reload_status got done=%b cnt=%0d want 0/0", load_done, byte_count); end
    endtask

    task automatic test_gaps;
        logic [4:0] v = 5'b11001;
        logic [4:0] exp_addr = 5'd0;
        for (int i = 0; i < 5; i++) begin
            in_valid = v[i]; in_data = 8'hA0 + 8'(i); in_last = (i == 4);
            tick;
            checks++; if (mem_wr !== v[i]) begin errors++; $display("FAIL gap_wr%0d got %b want %b", i, mem_wr, v[i]); end
            if (v[i]) begin
                checks++; if (mem_addr !== exp_addr || mem_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL gap_mem%0d got %h/%h want %h/%h", i, mem_addr, mem_data, exp_addr, 8'hA0 + 8'(i)); end
                exp_addr++;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (byte_count !== 6'd3) begin errors++; $display("FAIL gap_count got %0d want 3", byte_count); end
        tick;
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL gap_run got %b want 0", cpu_rst); end
        cpu_halt = 1'b1; start_load = 1'b1;
        tick;
        cpu_halt = 1'b0; start_load = 1'b0;
        checks++; if (load_done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0 || run_cycles !== 16'd1) begin errors++; $display("FAIL halt_wins got done=%b rst=%b rdy=%b cyc=%0d want 1/0/0/1", load_done, cpu_rst, in_ready, run_cycles); end
        start_load = 1'b1;
        tick;
        start_load = 1'b0;
    endtask

    task automatic test_full32;
        for (int i = 0; i < 34; i++) begin
            in_valid = 1'b1; in_data = 8'(i * 7 + 3); in_last = 1'b0; cpu_halt = (i <= 32);
            tick;
            if (i < 32) begin
                checks++; if (mem_wr !== 1'b1 || mem_addr !== 5'(i) || mem_data !== 8'(i * 7 + 3)) begin errors++; $display("FAIL full_w%0d got %b/%h/%h want 1/%h/%h", i, mem_wr, mem_addr, mem_data, 5'(i), 8'(i * 7 + 3)); end
            end else begin
                checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL full_nowr%0d got %b want 0", i, mem_wr); end
            end
            if (i == 31) begin
                checks++; if (in_ready !== 1'b0 || byte_count !== 6'd32 || cpu_rst !== 1'b1) begin errors++; $display("FAIL full_term got rdy=%b cnt=%0d rst=%b want 0/32/1", in_ready, byte_count, cpu_rst); end
            end
            if (i == 33) begin
                checks++; if (cpu_rst !== 1'b0 || load_done !== 1'b1 || run_cycles !== 16'd1) begin errors++; $display("FAIL full_run got rst=%b done=%b cyc=%0d want 0/1/1", cpu_rst, load_done, run_cycles); end
            end
        end
        in_valid = 1'b0; cpu_halt = 1'b0; start_load = 1'b1;
        tick;
        start_load = 1'b0;
        checks++; if (cpu_rst !== 1'b0 || in_ready !== 1'b0 || run_cycles !== 16'd2) begin errors++; $display("FAIL run_ign_start got rst=%b rdy=%b cyc=%0d want 0/0/2", cpu_rst, in_ready, run_cycles); end
        cpu_halt = 1'b1;
        tick;
        cpu_halt = 1'b0; start_load = 1'b1;
        tick;
        start_load = 1'b0;
    endtask

    task automatic test_rst_abort;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'hD0 + 8'(i); in_last = 1'b0;
            tick;
        end
        checks++; if (mem_addr !== 5'd1 || mem_data !== 8'hD1) begin errors++; $display("FAIL abort_pre got %h/%h want 01/d1", mem_addr, mem_data); end
        in_data = 8'hD2;
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 5'd0 || mem_data !== 8'h00) begin errors++; $display("FAIL abort_io got rdy=%b wr=%b %h/%h want 0/0/00/00", in_ready, mem_wr, mem_addr, mem_data); end
        checks++; if (cpu_rst !== 1'b1 || load_done !== 1'b0 || byte_count !== 6'd0 || run_cycles !== 16'd0) begin errors++; $display("FAIL abort_status got rst=%b done=%b cnt=%0d cyc=%0d want 1/0/0/0", cpu_rst, load_done, byte_count, run_cycles); end
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        tick;
        in_valid = 1'b1; in_data = 8'hC0; in_last = 1'b1;
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 5'd0 || mem_data !== 8'hC0 || byte_count !== 6'd1) begin errors++; $display("FAIL abort_restart got %b/%h/%h cnt=%0d want 1/00/c0/1", mem_wr, mem_addr, mem_data, byte_count); end
    endtask

`ifdef PROG_LOADER_CKSUM_EN
    task automatic send3(input logic [7:0] cks);
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 5'd0 || mem_data !== 8'h01) begin errors++; $display("FAIL ck_w0 got %b/%h/%h want 1/00/01", mem_wr, mem_addr, mem_data); end
        in_data = 8'h02;
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 5'd1 || mem_data !== 8'h02) begin errors++; $display("FAIL ck_w1 got %b/%h/%h want 1/01/02", mem_wr, mem_addr, mem_data); end
        in_data = cks; in_last = 1'b1;
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (mem_wr !== 1'b0 || byte_count !== 6'd2) begin errors++; $display("FAIL ck_nowr got %b cnt=%0d want 0/2", mem_wr, byte_count); end
    endtask

    task automatic test_cksum;
        send3(8'h04);
        tick;
        checks++; if (cksum_err !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL ck_bad got err=%b rst=%b done=%b want 1/1/0", cksum_err, cpu_rst, load_done); end
        start_load = 1'b1;
        tick;
        start_load = 1'b0;
        checks++; if (cksum_err !== 1'b0 || in_ready !== 1'b1 || byte_count !== 6'd0) begin errors++; $display("FAIL ck_reload got err=%b rdy=%b cnt=%0d want 0/1/0", cksum_err, in_ready, byte_count); end
        send3(8'h03);
        tick;
        checks++; if (cksum_err !== 1'b0 || cpu_rst !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL ck_good got err=%b rst=%b done=%b want 0/0/1", cksum_err, cpu_rst, load_done); end
    endtask
`endif

    initial begin
        test_reset;
`ifdef PROG_LOADER_CKSUM_EN
        test_cksum;
`else
        test_stream3;
        test_run_halt;
        test_gaps;
        test_full32;
        test_rst_abort;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
